// File: rtl/bus_master_if.sv
// Host command/response handshake plus the bus address and strobes of
// bus_master. The bidirectional DATA bus is a plain inout port on the master.
interface bus_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [11:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        cmd_autoinc;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [11:0] ADDR;
   logic        RD;
   logic        WR;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_autoinc,
      output cmd_ready, rsp_valid, rsp_rdata, ADDR, RD, WR
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_autoinc,
      input  cmd_ready, rsp_valid, rsp_rdata, ADDR, RD, WR
   );
endinterface

// File: rtl/bus_master.sv
// bus_master: runs one host command at a time as an asynchronous-style
// parallel bus cycle (SETUP -> STROBE -> HOLD -> TURN) with active-low RD/WR.
// Optional macro BUS_MASTER_AUTOINC_EN adds an auto-incrementing address
// pointer selected per command by cmd_autoinc.
module bus_master #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 2
) (
   input  logic              clk,
   input  logic              rst,
   bus_master_if.master      bif,
   inout  wire  [15:0]       DATA
);

   // Zero-length phases are stretched to one cycle.
   localparam int unsigned SETUP_N  = (SETUP_CYC  == 0) ? 1 : SETUP_CYC;
   localparam int unsigned STROBE_N = (STROBE_CYC == 0) ? 1 : STROBE_CYC;
   localparam int unsigned HOLD_N   = (HOLD_CYC   == 0) ? 1 : HOLD_CYC;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic        w_accept;
   logic        w_strobe_end;
   logic        w_drive;
   logic [11:0] w_addr_sel;

   logic        r_wr;
   logic [11:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_rdata;

   // State and phase-cycle counter; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: each phase counts its own cycles from zero.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt + 16'd1;
      w_accept     = 1'b0;
      w_strobe_end = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (bif.cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (r_cnt == 16'(SETUP_N - 1)) begin
               w_state_nxt = STROBE;
               w_cnt_nxt   = '0;
            end
         end
         STROBE: begin
            if (r_cnt == 16'(STROBE_N - 1)) begin
               w_state_nxt  = HOLD;
               w_cnt_nxt    = '0;
               w_strobe_end = 1'b1;
            end
         end
         HOLD: begin
            if (r_cnt == 16'(HOLD_N - 1)) begin
               w_state_nxt = TURN;
               w_cnt_nxt   = '0;
            end
         end
         TURN: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef BUS_MASTER_AUTOINC_EN
   logic [11:0] r_ptr;

   assign w_addr_sel = bif.cmd_autoinc ? r_ptr : bif.cmd_addr;

   // Pointer always lands one past the address just issued, wrapping at 0xFFF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= w_addr_sel + 12'd1;
      end
   end
`else
   logic w_unused_autoinc;

   assign w_unused_autoinc = bif.cmd_autoinc;
   assign w_addr_sel       = bif.cmd_addr;
`endif

   // Command latch on accept; ADDR keeps its value until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_wr    <= bif.cmd_wr;
         r_addr  <= w_addr_sel;
         r_wdata <= bif.cmd_wdata;
      end
   end

   // Read capture on the edge closing STROBE; the valid pulse lands in HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_strobe_end && !r_wr;
         if (w_strobe_end && !r_wr) begin
            r_rsp_rdata <= DATA;
         end
      end
   end

   // Strobes and bus enable decode straight from state so reset clears them at once.
   assign w_drive       = r_wr && ((r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD));
   assign DATA          = w_drive ? r_wdata : 16'hzzzz;
   assign bif.cmd_ready = (r_state == IDLE) && !rst;
   assign bif.RD        = !((r_state == STROBE) && !r_wr);
   assign bif.WR        = !((r_state == STROBE) && r_wr);
   assign bif.ADDR      = r_addr;
   assign bif.rsp_valid = r_rsp_valid;
   assign bif.rsp_rdata = r_rsp_rdata;

endmodule
